// File: rtl/ir_pkg.sv
// ir_pkg: shared constants, types and the output round/saturate helper
// for the cabinet impulse-response convolver.
//
// Contents:
//   N_TAPS, W, ACC_W, FRAC : datapath geometry (Q1.15 samples and weights)
//   sample_t / acc_t / ptr_t / state_t : common types
//   round_sat()            : acc -> Q1.15 sample, round half up, saturated
package ir_pkg;

    localparam int N_TAPS = 128;
    localparam int W      = 16;
    localparam int ACC_W  = 40;
    localparam int FRAC   = 15;
    localparam int PTR_W  = $clog2(N_TAPS);

    typedef logic signed [W-1:0]     sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [PTR_W-1:0]        ptr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam acc_t ROUND_BIAS = acc_t'(2 ** (FRAC - 1));
    localparam acc_t SAT_MAX    = acc_t'(2 ** (W - 1) - 1);
    localparam acc_t SAT_MIN    = -acc_t'(2 ** (W - 1));

    // Adding half an LSB before the arithmetic shift gives round-half-up
    // for both signs. The accumulator has enough headroom that the bias
    // addition itself can never wrap.
    function automatic sample_t round_sat(input acc_t acc);
        acc_t biased;
        acc_t shifted;
        biased  = acc + ROUND_BIAS;
        shifted = biased >>> FRAC;
        if (shifted > SAT_MAX) begin
            return sample_t'(SAT_MAX[W-1:0]);
        end else if (shifted < SAT_MIN) begin
            return sample_t'(SAT_MIN[W-1:0]);
        end else begin
            return sample_t'(shifted[W-1:0]);
        end
    endfunction

endpackage

// File: rtl/ir_convolver_mac.sv
// ir_mac: one signed W x W multiplier feeding an ACC_W accumulator.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears accumulator)
//   clear      : synchronous clear of the accumulator (wins over en)
//   en         : add the current product into the accumulator
//   sample     : signed Q1.15 delay-line operand
//   weight     : signed Q1.15 coefficient operand
//   sum        : accumulator + current product (combinational), so the
//                caller can capture the final total on the same edge the
//                last product is accumulated
module ir_mac
    import ir_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [W-1:0]     sample,
    input  logic signed [W-1:0]     weight,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*W-1:0] product;
    acc_t                  acc_reg;

    // Full-precision product, sign-extended into the accumulator; the
    // accumulator is wide enough that no intermediate saturation is needed.
    assign product = (2*W)'(sample) * (2*W)'(weight);
    assign sum     = acc_reg + ACC_W'(product);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= sum;
        end
    end

endmodule

// File: rtl/ir_convolver.sv
// ir_convolver: time-multiplexed N_TAPS-tap FIR used to convolve the
// guitar signal with a cabinet impulse response.
//
// One sample is accepted per in_valid/in_ready handshake and written into a
// circular delay line. The block then spends N_TAPS cycles multiplying
// x[n-k] by weights[k] for k = 0..N_TAPS-1 and finally presents a rounded,
// saturated Q1.15 result with a single-cycle out_valid pulse.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : upstream has a sample
//   in_ready    : block can take a sample (low only while multiplying)
//   in_sample   : signed Q1.15 input sample
//   weights     : packed coefficient vector, weights[k] multiplies x[n-k];
//                 must stay stable while a sample is being processed
//   out_valid   : one-cycle result strobe
//   out_sample  : signed Q1.15 result, held until the next result
module ir_convolver
    import ir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [W-1:0]       in_sample,
    input  logic [N_TAPS-1:0][W-1:0]  weights,
    output logic                      out_valid,
    output logic signed [W-1:0]       out_sample
);

    state_t  state_reg;
    state_t  state_next;
    ptr_t    tap_reg;
    ptr_t    wr_ptr_reg;
    sample_t dline_reg [N_TAPS];
    sample_t out_sample_reg;

    logic              accept;
    logic              last_tap;
    logic              mac_en;
    ptr_t              rd_idx;
    sample_t           tap_sample;
    sample_t           tap_weight;
    acc_t              mac_sum;
    logic [N_TAPS-1:0] wr_en;

    assign accept   = in_valid && in_ready;
    assign last_tap = (tap_reg == ptr_t'(N_TAPS - 1));

    // wr_ptr still points at the newest sample during MAC (it only advances
    // after the final tap), so newest-minus-k walks back through history and
    // wraps naturally in PTR_W bits.
    assign rd_idx     = wr_ptr_reg - tap_reg;
    assign tap_sample = dline_reg[rd_idx];
    assign tap_weight = sample_t'(weights[tap_reg]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                // Accepting in OUT skips IDLE so back-to-back samples run at
                // one per N_TAPS+1 cycles.
                state_next = accept ? MAC : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        mac_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            MAC: begin
                in_ready = 1'b0;
                mac_en   = 1'b1;
            end
            OUT: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // ---------------- tap counter, write pointer, result ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_reg        <= '0;
            wr_ptr_reg     <= '0;
            out_sample_reg <= '0;
        end else begin
            if (accept) begin
                tap_reg <= '0;
            end else if (mac_en) begin
                tap_reg <= tap_reg + ptr_t'(1);
            end

            // The final product is folded in combinationally so the result
            // is registered on the same edge that enters OUT.
            if (mac_en && last_tap) begin
                wr_ptr_reg     <= wr_ptr_reg + ptr_t'(1);
                out_sample_reg <= round_sat(mac_sum);
            end
        end
    end

    assign out_sample = out_sample_reg;

    // ---------------- delay line ----------------
    // One-hot write enable decoded per entry.
    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_wr_en
            assign wr_en[gi] = accept && (wr_ptr_reg == ptr_t'(gi));
        end
    endgenerate

    // Reset clears history, so an aborted sample leaves no trace and the
    // first output after reset sees zeros for every older tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                dline_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_TAPS; i++) begin
                if (wr_en[i]) begin
                    dline_reg[i] <= in_sample;
                end
            end
        end
    end

    // ---------------- multiply-accumulate ----------------
    ir_mac u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (accept),
        .en     (mac_en),
        .sample (tap_sample),
        .weight (tap_weight),
        .sum    (mac_sum)
    );

endmodule
